// File: rtl/serial_pkg.sv
// Shared types and helpers for the parametrised UART with buffered TX/RX paths.
package serial_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Parity bit to transmit (or expect) for a zero-extended data word.
  function automatic logic parity_calc(input logic [7:0] data, input parity_e mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_sync_fifo.sv
// Generic synchronous FIFO with show-ahead read data and occupancy count.
// Latency: a write is visible at rd_dat on the cycle after the write edge.
// Backpressure: writes ignored while full, reads ignored while empty; a write is refused when full even if a read happens on the same edge.
module serial_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign level  = wr_ptr - rd_ptr;
  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/serial_fifo_interface.sv
// Full-duplex UART between the board pins and packet logic, with TX and RX FIFOs and sticky RX error flags.
// Latency: start bit within 2 cycles of accepting into an empty TX path; RX byte pushed on the stop-bit sample cycle.
// Backpressure: tx_ready low while the TX FIFO is full; RX drops good bytes into overrun when its FIFO is full.
module serial_fifo_interface
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 869,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_uart,
  output logic [DATA_BITS-1:0]          rx_byte,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic [DATA_BITS-1:0]          tx_byte,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_uart,
  output logic                          tx_busy,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam int              CW       = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int              LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);
  localparam parity_e         PMODE    = parity_e'(PARITY_MODE);

  // ---------------- TX path ----------------
  uart_state_e           tx_state;
  logic [CW-1:0]         tx_cnt;
  logic [2:0]            tx_bit;
  logic [DATA_BITS-1:0]  tx_shift;
  logic                  tx_par;
  logic [DATA_BITS-1:0]  tx_head;
  logic                  tx_full;
  logic                  tx_empty;
  logic [LW-1:0]         tx_level;
  logic                  tx_pop;

  // Pop in IDLE, or on the last STOP cycle so back-to-back frames have no gap.
  assign tx_pop   = !tx_empty && ((tx_state == IDLE) || (tx_state == STOP && tx_cnt == STOP_END));
  assign tx_ready = !tx_full;
  assign tx_busy  = (tx_level != '0) || (tx_state != IDLE);

  serial_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (tx_valid),
    .wr_dat (tx_byte),
    .rd_rdy (tx_pop),
    .rd_dat (tx_head),
    .full   (tx_full),
    .empty  (tx_empty),
    .level  (tx_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_uart  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          tx_uart <= 1'b1;
          if (tx_pop) begin
            tx_shift <= tx_head;
            tx_par   <= parity_calc(8'(tx_head), PMODE);
            tx_cnt   <= '0;
            tx_state <= START;
            tx_uart  <= 1'b0;
          end
        end
        START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_uart  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= DATA;
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
              if (PMODE != PAR_NONE) begin
                tx_uart  <= tx_par;
                tx_state <= PARITY;
              end else begin
                tx_uart  <= 1'b1;
                tx_state <= STOP;
              end
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_uart  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        PARITY: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_uart  <= 1'b1;
            tx_state <= STOP;
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        STOP: begin
          if (tx_cnt == STOP_END) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= tx_head;
              tx_par   <= parity_calc(8'(tx_head), PMODE);
              tx_uart  <= 1'b0;
              tx_state <= START;
            end else begin
              tx_uart  <= 1'b1;
              tx_state <= IDLE;
            end
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        default: begin
          tx_uart  <= 1'b1;
          tx_state <= IDLE;
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  uart_state_e           rx_state;
  logic [CW-1:0]         rx_cnt;
  logic [2:0]            rx_bit;
  logic [DATA_BITS-1:0]  rx_shift;
  logic                  rx_par_bad;
  logic                  rx_wait_hi;
  logic                  rx_s1;
  logic                  rx_s2;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  rx_stop_smp;
  logic                  rx_good;
  logic                  rx_push;

  assign rx_stop_smp = (rx_state == STOP) && !rx_wait_hi && (rx_cnt == BIT_END);
  assign rx_good     = rx_stop_smp && rx_s2 && !rx_par_bad;
  assign rx_push     = rx_good && !rx_full;
  assign rx_valid    = !rx_empty;

  serial_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (rx_push),
    .wr_dat (rx_shift),
    .rd_rdy (rx_ready),
    .rd_dat (rx_byte),
    .full   (rx_full),
    .empty  (rx_empty),
    .level  (rx_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_uart;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
      rx_wait_hi <= 1'b0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (!rx_s2) begin
            rx_cnt     <= '0;
            rx_par_bad <= 1'b0;
            rx_state   <= START;
          end
        end
        START: begin
          // Half-bit re-sample rejects glitches and aligns later samples to mid-bit.
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) rx_state <= (PMODE != PAR_NONE) ? PARITY : STOP;
            else                    rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        PARITY: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt     <= '0;
            rx_par_bad <= (rx_s2 != parity_calc(8'(rx_shift), PMODE));
            rx_state   <= STOP;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        STOP: begin
          if (rx_wait_hi) begin
            if (rx_s2) begin
              rx_wait_hi <= 1'b0;
              rx_state   <= IDLE;
            end
          end else if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            if (rx_s2) rx_state   <= IDLE;
            else       rx_wait_hi <= 1'b1;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a new error on the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_frame_err  <= (rx_stop_smp && !rx_s2) || (rx_frame_err && !err_clr);
      rx_parity_err <= (rx_stop_smp && rx_s2 && rx_par_bad) || (rx_parity_err && !err_clr);
      rx_overrun    <= (rx_good && rx_full) || (rx_overrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_serial_fifo_interface.sv
// Directed bench: 8N1 TX waveform on one instance; 8E1 depth-4 loopback, error and reset cases on another.
module tb_serial_fifo_interface;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  // 8E1, depth 4 instance
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_ready = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0, tx_ready, tx_uart, tx_busy;
  logic       rx_frame_err, rx_parity_err, rx_overrun, err_clr = 1'b0;
  logic [2:0] rx_level;

  assign rx_line = loop_en ? tx_uart : rx_drv;

  serial_fifo_interface #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_line), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_uart(tx_uart), .tx_busy(tx_busy), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun), .err_clr(err_clr), .rx_level(rx_level)
  );

  // 8N1, depth 16 instance (TX only)
  logic [7:0] n_rx_byte;
  logic       n_rx_valid, n_tx_ready, n_tx_uart, n_tx_busy;
  logic       n_rx_frame_err, n_rx_parity_err, n_rx_overrun;
  logic [4:0] n_rx_level;
  logic [7:0] n_tx_byte = 8'h00;
  logic       n_tx_valid = 1'b0;

  serial_fifo_interface #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_n (
    .clk(clk), .rst_n(rst_n), .rx_uart(1'b1), .rx_byte(n_rx_byte), .rx_valid(n_rx_valid),
    .rx_ready(1'b0), .tx_byte(n_tx_byte), .tx_valid(n_tx_valid), .tx_ready(n_tx_ready),
    .tx_uart(n_tx_uart), .tx_busy(n_tx_busy), .rx_frame_err(n_rx_frame_err),
    .rx_parity_err(n_rx_parity_err), .rx_overrun(n_rx_overrun), .err_clr(1'b0), .rx_level(n_rx_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic bit_out(input logic v);
    rx_drv = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    @(posedge clk);
    #1;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(par);
    bit_out(stp);
    bit_out(1'b1);
  endtask

  task automatic expect_rx(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    @(negedge clk);
    while (!rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rx_valid || sb.size() == 0) begin
      fail_timeout(tag);
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check(tag, rx_byte, e);
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) fail_timeout("tx_write_ready");
    else begin
      tx_byte  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] lb [5];
    logic [7:0] ob [5];
    logic [9:0] fr;
    int ca, c1, c2, n;
    lb = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5A};
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_uart", tx_uart, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_rx_byte", rx_byte, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 waveform of 0xA5
    @(posedge clk);
    #1;
    n_tx_byte  = 8'hA5;
    n_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    ca = cyc;
    n_tx_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (n_tx_uart && n < 8) begin
      @(negedge clk);
      n++;
    end
    c1 = cyc;
    check("tx_start_latency_le2", 32'((c1 - ca) <= 2), 1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      while (cyc < c1 + 16 * k + 8) @(negedge clk);
      check($sformatf("tx_8n1_bit%0d", k), n_tx_uart, fr[k]);
    end
    n = 0;
    while (n_tx_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    c2 = cyc;
    check("tx_8n1_frame_len", c2 - c1, 160);

    // 8E1 loopback with back-to-back writes filling the TX FIFO
    loop_en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      tx_byte  = lb[i];
      tx_valid = 1'b1;
      sb.push_back(lb[i]);
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    check("tx_ready_full", tx_ready, 0);
    for (int i = 0; i < 5; i++) expect_rx($sformatf("loop_rx%0d", i));
    n = 0;
    while (tx_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("loop_tx_idle", tx_busy, 0);
    check("loop_no_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    check("loop_rx_level", rx_level, 0);
    repeat (20) @(posedge clk);
    #1 loop_en = 1'b0;

    // Parity error
    send_frame(8'h03, 1'b1, 1'b1);
    @(negedge clk);
    check("par_rx_valid", rx_valid, 0);
    check("par_err_set", rx_parity_err, 1);
    pulse_clr();
    @(negedge clk);
    check("par_err_clr", rx_parity_err, 0);

    // Framing error, then a good frame
    send_frame(8'h55, even_par(8'h55), 1'b0);
    @(negedge clk);
    check("frm_rx_valid", rx_valid, 0);
    check("frm_err_set", rx_frame_err, 1);
    sb.push_back(8'h12);
    send_frame(8'h12, even_par(8'h12), 1'b1);
    expect_rx("frm_next_rx");
    pulse_clr();
    @(negedge clk);
    check("frm_err_clr", rx_frame_err, 0);

    // Overrun with consumer stalled
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(ob[i]);
      send_frame(ob[i], even_par(ob[i]), 1'b1);
    end
    @(negedge clk);
    check("ovr_rx_level", rx_level, 4);
    check("ovr_set", rx_overrun, 1);
    check("ovr_no_par_err", rx_parity_err, 0);
    for (int i = 0; i < 4; i++) expect_rx($sformatf("ovr_rx%0d", i));
    @(negedge clk);
    check("ovr_drained", rx_level, 0);
    pulse_clr();
    @(negedge clk);
    check("ovr_clr", rx_overrun, 0);

    // Glitch on the RX line
    @(posedge clk);
    #1 rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rx_valid", rx_valid, 0);
    check("glitch_no_frame_err", rx_frame_err, 0);

    // Reset during a TX frame
    tx_write(8'hC3);
    tx_write(8'h3C);
    n = 0;
    @(negedge clk);
    while (tx_uart && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("pre_rst_tx_low", tx_uart, 0);
    check("pre_rst_busy", tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_uart", tx_uart, 1);
    check("rst_mid_tx_ready", tx_ready, 1);
    check("rst_mid_tx_busy", tx_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_tx_idle", tx_uart, 1);
    check("post_rst_busy", tx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
